tv_gen: RTL and testbench
=========================

# tv_gen

Exhaustive stimulus generator for 3-input combinational blocks such as gate-level cells and small decoders. After reset it drives every 3-bit input combination onto `in2`/`in1`/`in0` in a fixed order, holding each vector for a programmable number of clocks. Status outputs mark sweep boundaries so a bench can align checks or stop simulation. The block sits in the simulation harness between the clock/reset generator and the unit under test.

## Interface
Parameters:
- `STEP_CYCLES`, default 1: clocks each vector is held. Legal range 1..255.
- `WRAP`, default 1: 1 restarts the sweep after the last vector; 0 stops on the last vector.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  reset; synchronous and active-low.
- `in0`  output  1  vector bit 0 (LSB).
- `in1`  output  1  vector bit 1.
- `in2`  output  1  vector bit 2 (MSB).
- `vec_idx`  output  3  sequence position 0..7 of the vector currently driven.
- `sweep_done`  output  1  one-clock pulse when a full 8-vector sweep completes.
- `sweep_cnt`  output  8  number of completed sweeps, saturating at 255.
- `finished`  output  1  level; high once stopped (WRAP=0 only).

## Operation
- State: 3-bit `vec_idx`, 8-bit hold counter `hc`, `sweep_cnt`, `sweep_done`, `finished`, all registered.
- `{in2,in1,in0}` = code(`vec_idx`).
  - Default code is binary, so code(i) = i.
  - The Gray option is in Configuration.
  - Outputs are driven directly from registers, not decoded combinationally.
- Reset (`rst`=0 at a rising edge):
  - `vec_idx`=0, `hc`=0, `sweep_cnt`=0, `sweep_done`=0, `finished`=0.
  - Vector output is 000.
- Advance, at each rising edge with `rst`=1 and `finished`=0:
  - If `hc` < STEP_CYCLES-1: `hc` increments; vector unchanged.
  - Otherwise `hc`=0 and `vec_idx` advances.
- Advance from `vec_idx`=7 with WRAP=1:
  - `vec_idx` becomes 0 and `sweep_done`=1 for that one clock.
  - `sweep_cnt` increments, holding at 255.
- Advance from `vec_idx`=7 with WRAP=0:
  - `vec_idx` stays 7, `sweep_done` pulses once, `sweep_cnt` increments, and `finished` goes to 1.
  - All state then freezes until reset.
- `sweep_done` is 0 in every cycle other than those above.

## Timing
- Reset is sampled only on rising edges; no asynchronous path exists.
- Vector 000 is driven during reset and until the first rising edge with `rst`=1.
- With STEP_CYCLES=1, that first edge produces vector 1, and each later edge advances by one.
- With STEP_CYCLES=N, every vector, including the first 000 after release, is held for exactly N rising edges counted from reset release.
- Latency from the advance edge to a new output value is zero additional cycles: outputs change on that edge.
- `sweep_done` coincides with the first cycle of vector 0 (WRAP=1) or the first frozen cycle (WRAP=0).
- Reset asserted mid-sweep returns all state to reset values on that edge, including `sweep_cnt` and `finished`.
- With STEP_CYCLES=1 and WRAP=1, one sweep spans 8 clocks, and the sequence repeats indefinitely.

## Configuration
- `TV_GEN_GRAY_EN` defined: code(i) = i ^ (i>>1), giving the sequence 000,001,011,010,110,111,101,100.
  - Exactly one input toggles per step, including the 100→000 wrap.
- `TV_GEN_GRAY_EN` undefined: binary order 000..111.
- Sweep-control logic and status outputs are identical in both builds.

## Test plan
- Default build, STEP_CYCLES=1, WRAP=1, reset low 1 clock then high 16 clocks.
  - Required: `{in2,in1,in0}` runs 000,001,…,111,000,…,111.
  - Required: `sweep_done` high exactly on the 8th and 16th post-release edges; `sweep_cnt`=2 at the end.
- STEP_CYCLES=3: each vector is held exactly 3 clocks, and 111→000 occurs on post-release edge 24.
- WRAP=0, 20 clocks after release.
  - Required: 111 holds from edge 7 onward.
  - Required: `finished`=1 from edge 8 onward; `sweep_done` pulses only at edge 8; `sweep_cnt`=1.
- Reset mid-sweep at vector 101, `sweep_cnt`=1.
  - Required: on the next edge with `rst`=0, outputs are 000, `vec_idx`=0, and `sweep_cnt`=0.
  - Required: after release the sequence resumes at 001.
- `TV_GEN_GRAY_EN` build: outputs follow 000,001,011,010,110,111,101,100, with one bit toggling per step across 16 clocks.
- Driving a 3-input AND: its output is high only while vector 111 is driven, once per sweep.

Source files
------------

// File: rtl/tv_gen_if.sv
// Vector and sweep-status bundle between tv_gen (master) and the harness (slave).
// Pure wiring, no latency; no backpressure.
// The vector bits feed the unit under test; the rest serve bench alignment.
interface tv_gen_if;
    logic       in0;
    logic       in1;
    logic       in2;
    logic [2:0] vec_idx;
    logic       sweep_done;
    logic [7:0] sweep_cnt;
    logic       finished;

    modport master (
        output in0, in1, in2, vec_idx, sweep_done, sweep_cnt, finished
    );

    modport slave (
        input in0, in1, in2, vec_idx, sweep_done, sweep_cnt, finished
    );
endinterface

// File: rtl/tv_gen.sv
// Exhaustive 3-bit stimulus sweep, each vector held STEP_CYCLES clocks; TV_GEN_GRAY_EN selects Gray order.
// Latency: outputs change on the advancing edge, all driven straight from registers.
// Backpressure: none; free-running until reset, or frozen on the last vector when WRAP=0.
module tv_gen #(
    parameter int STEP_CYCLES = 1,
    parameter bit WRAP        = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    tv_gen_if.master tv
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_STOP = 1'b1
    } state_t;

    localparam logic [7:0] HC_MAX = 8'(STEP_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [2:0] vec_q, vec_d;
    logic [7:0] hc_q, hc_d;
    logic [7:0] cnt_q, cnt_d;
    logic       done_q, done_d;
    logic       step;

    function automatic logic [2:0] code(input logic [2:0] i);
`ifdef TV_GEN_GRAY_EN
        return i ^ (i >> 1);
`else
        return i;
`endif
    endfunction

    assign step = (state_q == ST_RUN) && (hc_q >= HC_MAX);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_RUN;
            idx_q   <= 3'd0;
            vec_q   <= 3'd0;
            hc_q    <= 8'd0;
            cnt_q   <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
            hc_q    <= hc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (step && (idx_q == 3'd7) && !WRAP) begin
            state_d = ST_STOP;
        end
    end

    // The vector is re-encoded from the next index so in0..in2 leave a flop, not a decoder.
    always_comb begin
        idx_d  = idx_q;
        hc_d   = hc_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (state_q == ST_RUN) begin
            if (step) begin
                hc_d = 8'd0;
                if (idx_q == 3'd7) begin
                    done_d = 1'b1;
                    if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    idx_d = WRAP ? 3'd0 : 3'd7;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end else begin
                hc_d = hc_q + 8'd1;
            end
        end
        vec_d = code(idx_d);
    end

    assign tv.in0        = vec_q[0];
    assign tv.in1        = vec_q[1];
    assign tv.in2        = vec_q[2];
    assign tv.vec_idx    = idx_q;
    assign tv.sweep_done = done_q;
    assign tv.sweep_cnt  = cnt_q;
    assign tv.finished   = (state_q == ST_STOP);

endmodule

// File: tb/tb_tv_gen.sv
// Directed bench: three generators (step 1 wrap, step 3 wrap, step 1 stop) swept side by side.
// Mid-sweep reset on the first instance, and a 3-input AND as the unit under test.
module tb_tv_gen;

    logic clk;
    logic rst_a;
    logic rst_bc;
    int   checks;
    int   failures;

    tv_gen_if if_a ();
    tv_gen_if if_b ();
    tv_gen_if if_c ();

    tv_gen #(.STEP_CYCLES(1), .WRAP(1'b1)) u_a (.clk(clk), .rst(rst_a),  .tv(if_a));
    tv_gen #(.STEP_CYCLES(3), .WRAP(1'b1)) u_b (.clk(clk), .rst(rst_bc), .tv(if_b));
    tv_gen #(.STEP_CYCLES(1), .WRAP(1'b0)) u_c (.clk(clk), .rst(rst_bc), .tv(if_c));

    logic       and_a;
    logic [2:0] vec_a, vec_b, vec_c;
    assign and_a = if_a.in2 & if_a.in1 & if_a.in0;
    assign vec_a = {if_a.in2, if_a.in1, if_a.in0};
    assign vec_b = {if_b.in2, if_b.in1, if_b.in0};
    assign vec_c = {if_c.in2, if_c.in1, if_c.in0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int code(input int i);
`ifdef TV_GEN_GRAY_EN
        case (i)
            0: return 0;
            1: return 1;
            2: return 3;
            3: return 2;
            4: return 6;
            5: return 7;
            6: return 5;
            default: return 4;
        endcase
`else
        return i;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag, input logic [2:0] v, input logic [2:0] idx,
                             input logic [7:0] cnt, input logic dn, input logic fin);
        chk({tag, "_vec"},  0, 32'(v),   32'd0);
        chk({tag, "_idx"},  0, 32'(idx), 32'd0);
        chk({tag, "_cnt"},  0, 32'(cnt), 32'd0);
        chk({tag, "_done"}, 0, 32'(dn),  32'd0);
        chk({tag, "_fin"},  0, 32'(fin), 32'd0);
    endtask

    initial begin
        logic [2:0] prev_a;
        checks   = 0;
        failures = 0;
        rst_a    = 1'b0;
        rst_bc   = 1'b0;

        tick();
        chk_reset("rst_a", vec_a, if_a.vec_idx, if_a.sweep_cnt, if_a.sweep_done, if_a.finished);
        chk_reset("rst_b", vec_b, if_b.vec_idx, if_b.sweep_cnt, if_b.sweep_done, if_b.finished);
        chk_reset("rst_c", vec_c, if_c.vec_idx, if_c.sweep_cnt, if_c.sweep_done, if_c.finished);

        rst_a  = 1'b1;
        rst_bc = 1'b1;
        prev_a = vec_a;

        for (int k = 1; k <= 24; k++) begin
            tick();
            // Step 1, wrapping: one vector per edge, sweep ends every 8th edge.
            chk("a_vec",  k, 32'(vec_a),           32'(code(k % 8)));
            chk("a_idx",  k, 32'(if_a.vec_idx),    32'(k % 8));
            chk("a_done", k, 32'(if_a.sweep_done), 32'(k % 8 == 0));
            chk("a_cnt",  k, 32'(if_a.sweep_cnt),  32'(k / 8));
            chk("a_and",  k, 32'(and_a),           32'(code(k % 8) == 7));
`ifdef TV_GEN_GRAY_EN
            chk("a_gray1", k, 32'($countones(vec_a ^ prev_a)), 32'd1);
`endif
            prev_a = vec_a;
            // Step 3: each vector lasts 3 edges, 111 -> 000 on edge 24.
            chk("b_vec",  k, 32'(vec_b),           32'(code((k / 3) % 8)));
            chk("b_done", k, 32'(if_b.sweep_done), 32'(k == 24));
            chk("b_cnt",  k, 32'(if_b.sweep_cnt),  32'(k / 24));
            // No wrap: 111 from edge 7, frozen from edge 8.
            chk("c_vec",  k, 32'(vec_c),           32'(code(k < 7 ? k : 7)));
            chk("c_idx",  k, 32'(if_c.vec_idx),    32'(k < 7 ? k : 7));
            chk("c_fin",  k, 32'(if_c.finished),   32'(k >= 8));
            chk("c_done", k, 32'(if_c.sweep_done), 32'(k == 8));
            chk("c_cnt",  k, 32'(if_c.sweep_cnt),  32'(k >= 8 ? 1 : 0));
        end

        // Move instance a to index 5 of its fourth sweep, then reset it there.
        for (int k = 25; k <= 29; k++) begin
            tick();
        end
        chk("a_mid_idx", 29, 32'(if_a.vec_idx),   32'd5);
        chk("a_mid_cnt", 29, 32'(if_a.sweep_cnt), 32'd3);

        rst_a = 1'b0;
        tick();
        chk_reset("midrst_a", vec_a, if_a.vec_idx, if_a.sweep_cnt, if_a.sweep_done, if_a.finished);
        chk("c_frozen_fin", 30, 32'(if_c.finished), 32'd1);
        chk("c_frozen_vec", 30, 32'(vec_c),         32'(code(7)));
        chk("c_frozen_cnt", 30, 32'(if_c.sweep_cnt), 32'd1);

        rst_a = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk("a_resume_vec",  k, 32'(vec_a),           32'(code(k % 8)));
            chk("a_resume_done", k, 32'(if_a.sweep_done), 32'(k == 8));
            chk("a_resume_cnt",  k, 32'(if_a.sweep_cnt),  32'(k / 8));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
